fetch_unit: RTL and testbench

- Instruction fetch front end for the simple CPU core. It sits upstream of decode/execute in mainP and feeds it one {pc, instr} per handshake.
- Owns the program counter and drives a req/ack instruction-memory port that tolerates variable latency.
- Buffers fetched words in a small prefetch FIFO.
- Accepts branch/jump redirects from execute and discards stale fetches.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
// A FIFO entry is laid out as {pc, instr} with the pc in the upper bits.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned INSTR_W_DEF = 16;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

    function automatic int unsigned entry_w(input int unsigned aw, input int unsigned iw);
        return aw + iw;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with a registered head (zero when empty) and single-cycle flush.
module fetch_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        head_d = '0;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop)  rd_d = rd_q + 1'b1;
            if (push) wr_d = wr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            // The incoming word becomes head only when nothing older survives this cycle.
            if (push && (cnt_q == CNT_W'(pop))) head_d = push_data;
            else if (cnt_d != '0)                head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(pop && cnt_q == '0));
            assert (!(push && cnt_q == CNT_W'(DEPTH)));
        end
    end

    assign count = cnt_q;
    assign head  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, req/ack imem FSM, prefetch FIFO and redirect flush.
// Define FETCH_PERF_EN to add the saturating perf_fetched/perf_flushed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned INSTR_W    = INSTR_W_DEF,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic               clk,
    input  logic               pcrst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushed
`endif
);
    localparam int unsigned ENTRY_W = entry_w(ADDR_W, INSTR_W);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;

    logic               fifo_push, fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;

    // Redirect discards any ack arriving in the same cycle.
    assign fifo_push = (state_q == S_WAIT) && imem_ack && !redirect_valid;
    assign fifo_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!pcrst) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            req_q   <= 1'b0;
            addr_q  <= RST_PC;
        end else begin
            if (redirect_valid) pc_q <= redirect_pc;
            case (state_q)
                S_IDLE: begin
                    if (!redirect_valid && fifo_count < CNT_W'(FIFO_DEPTH)) begin
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                        if (!redirect_valid) pc_q <= pc_q + 1'b1;
                    end else if (redirect_valid) begin
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (pcrst),
        .push     (fifo_push),
        .push_data({pc_q, imem_rdata}),
        .pop      (fifo_pop),
        .flush    (redirect_valid),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_valid = (fifo_count != '0);
    assign out_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
    assign out_instr = fifo_head[INSTR_W-1:0];

`ifdef FETCH_PERF_EN
    logic [15:0] fetched_q, flushed_q;
    logic [16:0] flushed_d;

    // Entries popped in the redirect cycle reach decode, so they are not counted as flushed.
    assign flushed_d = {1'b0, flushed_q} + 17'(fifo_count) - 17'(fifo_pop)
                     + 17'(state_q == S_WAIT);

    always_ff @(posedge clk) begin
        if (!pcrst) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (fifo_push && fetched_q != '1) fetched_q <= fetched_q + 16'd1;
            if (redirect_valid) flushed_q <= flushed_d[16] ? '1 : flushed_d[15:0];
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then a random phase,
// all checked against an occupancy/program-order reference model.
module tb_fetch_unit;
    localparam int AW    = 8;
    localparam int IW    = 16;
    localparam int DEPTH = 2;
    localparam logic [AW-1:0] RST_PC = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          pcrst, imem_req, imem_ack, redirect_valid, out_valid, out_ready;
    logic [AW-1:0] imem_addr, redirect_pc, out_pc;
    logic [IW-1:0] imem_rdata, out_instr;
`ifdef FETCH_PERF_EN
    logic [15:0]   perf_fetched, perf_flushed;
`endif

    fetch_unit #(
        .ADDR_W(AW), .INSTR_W(IW), .FIFO_DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk), .pcrst(pcrst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder
    int            lat      = 1;
    int            wait_cnt = 0;
    logic          ovr_en   = 1'b0;
    logic [IW-1:0] ovr_val  = '0;

    // reference model: FIFO occupancy, in-flight request, program order
    int            occ      = 0;
    logic          m_req    = 1'b0;
    logic          stale    = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [AW-1:0] fetch_pc = '0;
    logic [AW-1:0] exp_pc   = '0;
    int            req_rises = 0;
    logic          prev_req = 1'b0;
`ifdef FETCH_PERF_EN
    int            m_fetched = 0;
    int            m_flushed = 0;
    int            perf_base = 0;
`endif

    int            k, n, ncap;
    logic          seen;
    logic [AW-1:0] cap_pc [4];
    logic [IW-1:0] cap_in [4];

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'h0100 + IW'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic          p_rst, p_redir, p_ack, p_pop, p_inflight;
        logic [AW-1:0] p_rpc;
        int            p_occ;
        p_rst      = !pcrst;
        p_redir    = redirect_valid;
        p_ack      = imem_ack;
        p_pop      = out_ready && (occ != 0);
        p_rpc      = redirect_pc;
        p_occ      = occ;
        p_inflight = m_req && !stale;
        @(posedge clk);
        #1;
        if (p_rst) begin
            occ      = 0;
            m_req    = 1'b0;
            stale    = 1'b0;
            fetch_pc = RST_PC;
            exp_pc   = RST_PC;
            ovr_en   = 1'b0;
`ifdef FETCH_PERF_EN
            m_fetched = 0;
            m_flushed = 0;
`endif
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_addr", 32'(imem_addr), 32'(RST_PC));
        end else begin
            if (p_pop) begin
                occ--;
                exp_pc++;
            end
            if (m_req) begin
                if (p_ack) begin
                    m_req = 1'b0;
                    if (!stale && !p_redir) begin
                        occ++;
                        fetch_pc++;
`ifdef FETCH_PERF_EN
                        if (m_fetched < 65535) m_fetched++;
`endif
                    end
                    stale = 1'b0;
                end else if (p_redir) begin
                    stale = 1'b1;
                end
            end else if (!p_redir && p_occ < DEPTH) begin
                m_req  = 1'b1;
                m_addr = fetch_pc;
            end
            if (p_redir) begin
`ifdef FETCH_PERF_EN
                m_flushed += p_occ - int'(p_pop) + int'(p_inflight);
                if (m_flushed > 65535) m_flushed = 65535;
`endif
                occ      = 0;
                fetch_pc = p_rpc;
                exp_pc   = p_rpc;
            end
            check("req", 32'(imem_req), 32'(m_req));
            if (m_req) check("addr", 32'(imem_addr), 32'(m_addr));
        end
        check("out_valid", 32'(out_valid), 32'(occ != 0));
        if (occ != 0) begin
            check("out_pc", 32'(out_pc), 32'(exp_pc));
            check("out_instr", 32'(out_instr), 32'(mem_word(exp_pc)));
        end else begin
            check("empty_pc", 32'(out_pc), 32'd0);
            check("empty_instr", 32'(out_instr), 32'd0);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", 32'(perf_fetched), 32'(m_fetched));
        check("perf_flushed", 32'(perf_flushed), 32'(m_flushed));
`endif
        if (imem_req && !prev_req) req_rises++;
        prev_req       = imem_req;
        redirect_valid = 1'b0;
        if (imem_ack) begin
            imem_ack = 1'b0;
        end else if (imem_req) begin
            if (wait_cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = ovr_en ? ovr_val : mem_word(imem_addr);
                ovr_en     = 1'b0;
                wait_cnt   = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (!imem_ack) imem_rdata = IW'($urandom);
    endtask

    task automatic do_reset();
        pcrst = 1'b0;
        step();
        pcrst = 1'b1;
    endtask

    initial begin
        pcrst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) step();

        // Basic stream: first valid 3 cycles after release, then pcs 0..3
        pcrst = 1'b1;
        k = 99; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            step();
            if (out_valid) begin seen = 1'b1; k = i; end
        end
        check("first_valid_latency", 32'(k), 32'd3);
        ncap = 0;
        for (int i = 0; i < 40 && ncap < 4; i++) begin
            if (out_valid && out_ready) begin
                cap_pc[ncap] = out_pc;
                cap_in[ncap] = out_instr;
                ncap++;
            end
            step();
        end
        check("stream_count", 32'(ncap), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("stream_pc", 32'(cap_pc[i]), 32'(i));
            check("stream_instr", 32'(cap_in[i]), 32'h100 + 32'(i));
        end

        // Backpressure: two fetches fill the FIFO, then requests stop
        do_reset();
        out_ready = 1'b0;
        n = req_rises;
        repeat (20) step();
        check("bp_fetches", 32'(req_rises - n), 32'd2);
        check("bp_req_idle", 32'(imem_req), 32'd0);
        check("bp_head_pc", 32'(out_pc), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        check("bp_resume_addr", 32'(imem_addr), 32'd2);

        // Slow memory: request and address held until the late ack
        do_reset();
        lat = 5;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        n = 0;
        while (imem_req && n < 20) begin
            check("slow_addr_stable", 32'(imem_addr), 32'd0);
            step();
            n++;
        end
        check("slow_req_cycles", 32'(n), 32'd6);
        check("slow_single_push", 32'(out_pc), 32'd0);
        lat = 1;

        // Redirect while waiting: late 0xDEAD must be discarded
        do_reset();
        lat = 3;
        step();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        ovr_en = 1'b1; ovr_val = 16'hDEAD;
        step();
        check("redir_flush_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 40 && !out_valid; i++) step();
        check("redir_first_pc", 32'(out_pc), 32'h40);
        check("redir_first_instr", 32'(out_instr), 32'h0140);

        // Redirect coinciding with ack, one entry buffered
        do_reset();
        lat = 1; out_ready = 1'b0;
        for (int i = 0; i < 20 && !(imem_ack && out_valid); i++) step();
        check("coinc_setup_ack", 32'(imem_ack), 32'd1);
`ifdef FETCH_PERF_EN
        perf_base = int'(perf_flushed);
`endif
        redirect_valid = 1'b1; redirect_pc = 8'h80;
        step();
        check("coinc_flush_valid", 32'(out_valid), 32'd0);
`ifdef FETCH_PERF_EN
        check("coinc_perf_flushed", 32'(int'(perf_flushed) - perf_base), 32'd2);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check("coinc_first_pc", 32'(out_pc), 32'h80);

        // PC wrap from 0xFF to 0x00
        redirect_valid = 1'b1; redirect_pc = 8'hFF;
        step();
        ncap = 0;
        for (int i = 0; i < 40 && ncap < 2; i++) begin
            if (out_valid && out_ready) begin
                cap_pc[ncap] = out_pc;
                ncap++;
            end
            step();
        end
        check("wrap_pc0", 32'(cap_pc[0]), 32'hFF);
        check("wrap_pc1", 32'(cap_pc[1]), 32'h00);

        // Reset in the middle of a wait
        lat = 4;
        for (int i = 0; i < 20 && !imem_req; i++) step();
        step();
        pcrst = 1'b0;
        step();
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        pcrst = 1'b1;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        check("midrst_resume_addr", 32'(imem_addr), 32'(RST_PC));

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) lat = $urandom_range(0, 3);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = AW'($urandom);
                if (m_req && !imem_ack) begin
                    ovr_en  = 1'b1;
                    ovr_val = IW'($urandom);
                end
            end
            pcrst = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
